// File: rtl/assert_fail_logger_if.sv
// assert_fail_logger_if
// Purpose : groups the check-input, failure-log handshake and status signals
//           of assert_fail_logger into one bundle.
// Signals : chk_valid/chk_pass   - check evaluation result (master -> slave)
//           log_valid/log_ready  - failure-log FIFO head handshake
//           log_time             - timestamp of FIFO head entry
//           fail_cnt/eval_cnt    - saturating failure / evaluation counters
//           first_fail_time      - timestamp of first failure since reset
//           any_fail/overflow    - sticky status flags
//           fifo_level           - FIFO occupancy
// Modports: slave  - the logger
//           master - the check source / log consumer
interface assert_fail_logger_if #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             chk_valid;
  logic             chk_pass;
  logic             log_valid;
  logic             log_ready;
  logic [TS_W-1:0]  log_time;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] eval_cnt;
  logic [TS_W-1:0]  first_fail_time;
  logic             any_fail;
  logic             overflow;
  logic [LW-1:0]    fifo_level;

  modport slave (
    input  chk_valid, chk_pass, log_ready,
    output log_valid, log_time, fail_cnt, eval_cnt, first_fail_time,
           any_fail, overflow, fifo_level
  );

  modport master (
    output chk_valid, chk_pass, log_ready,
    input  log_valid, log_time, fail_cnt, eval_cnt, first_fail_time,
           any_fail, overflow, fifo_level
  );
endinterface

// File: rtl/assert_fail_logger.sv
// assert_fail_logger
// Purpose : counts check evaluations and failures, timestamps each failure
//           with a free-running cycle counter and queues the timestamps in a
//           small FIFO for a downstream consumer.
// Ports   : clk  - clock, all logic on its rising edge
//           rst  - synchronous active-high reset
//           bus  - assert_fail_logger_if.slave (check input, log handshake,
//                  counters and status flags)
module assert_fail_logger #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  assert_fail_logger_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [TS_W-1:0]  r_cyc;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_eval_cnt;
  logic [TS_W-1:0]  r_first_time;
  logic             r_any_fail;
  logic             r_overflow;

  logic w_fail;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_fail  = bus.chk_valid & ~bus.chk_pass;
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = ~w_empty & bus.log_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_fail & (~w_full | w_pop);
  assign w_drop  = w_fail & w_full & ~w_pop;

  // Storage is not reset: log_time is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= r_cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_cyc        <= '0;
      r_fail_cnt   <= '0;
      r_eval_cnt   <= '0;
      r_first_time <= '0;
      r_any_fail   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 1'b1;

      // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      if (bus.chk_valid && (r_eval_cnt != '1)) r_eval_cnt <= r_eval_cnt + 1'b1;
      if (w_fail && (r_fail_cnt != '1))        r_fail_cnt <= r_fail_cnt + 1'b1;

      if (w_fail && !r_any_fail) begin
        r_any_fail   <= 1'b1;
        r_first_time <= r_cyc;
      end

      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.log_valid       = ~w_empty;
  assign bus.log_time        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fail_cnt        = r_fail_cnt;
  assign bus.eval_cnt        = r_eval_cnt;
  assign bus.first_fail_time = r_first_time;
  assign bus.any_fail        = r_any_fail;
  assign bus.overflow        = r_overflow;
  assign bus.fifo_level      = r_level;
endmodule

// File: tb/tb_assert_fail_logger.sv
// tb_assert_fail_logger
// Purpose : scoreboard bench for assert_fail_logger. A reference model updates
//           on each rising edge from the applied inputs and pushes expected
//           failure timestamps into a queue; a monitor on the falling edge
//           compares status outputs and pops the queue on each accepted entry.
module tb_assert_fail_logger;
  localparam int TS_W  = 16;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  assert_fail_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  assert_fail_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  int exp_q[$];
  int m_level, m_cyc, m_fail_raw, m_eval_raw, m_first;
  bit m_any, m_ovf;

  task automatic chk(string name, logic [31:0] act, int exp);
    n_tests++;
    if (act !== exp[31:0]) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Reference model: evaluated at every rising edge with the inputs of the
  // cycle that is ending.
  initial begin
    m_level = 0; m_cyc = 0; m_fail_raw = 0; m_eval_raw = 0; m_first = 0;
    m_any = 0; m_ovf = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_level = 0; m_cyc = 0; m_fail_raw = 0; m_eval_raw = 0; m_first = 0;
        m_any = 0; m_ovf = 0;
        exp_q.delete();
      end else begin
        bit pop, fail, pushed;
        pop    = (m_level > 0) && bus.log_ready;
        fail   = bus.chk_valid && !bus.chk_pass;
        pushed = 1'b0;
        if (bus.chk_valid) m_eval_raw++;
        if (fail) begin
          m_fail_raw++;
          if (!m_any) begin
            m_any   = 1'b1;
            m_first = m_cyc;
          end
          if (m_level == DEPTH && !pop) m_ovf = 1'b1;
          else begin
            exp_q.push_back(m_cyc);
            pushed = 1'b1;
          end
        end
        m_level = m_level - int'(pop) + int'(pushed);
        m_cyc   = (m_cyc + 1) % (1 << TS_W);
      end
    end
  end

  // Monitor: compares outputs mid-cycle, consumes accepted entries.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("fifo_level", 32'(bus.fifo_level), m_level);
        chk("log_valid", 32'(bus.log_valid), int'(m_level > 0));
        chk("fail_cnt", 32'(bus.fail_cnt), sat(m_fail_raw));
        chk("eval_cnt", 32'(bus.eval_cnt), sat(m_eval_raw));
        chk("any_fail", 32'(bus.any_fail), int'(m_any));
        chk("overflow", 32'(bus.overflow), int'(m_ovf));
        chk("first_fail_time", 32'(bus.first_fail_time), m_first);
        if (bus.log_valid === 1'b1) begin
          if (exp_q.size() > 0) chk("log_time", 32'(bus.log_time), exp_q[0]);
          else chk("log_unexpected", 32'(bus.log_time), -1);
        end else begin
          chk("log_time_idle", 32'(bus.log_time), 0);
        end
        if (!rst && bus.log_valid === 1'b1 && bus.log_ready && exp_q.size() > 0)
          void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(bit v, bit p, bit r);
    bus.chk_valid = v;
    bus.chk_pass  = p;
    bus.log_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    bus.chk_valid = 1'b0;
    bus.chk_pass  = 1'b1;
    bus.log_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // 10 evaluations, failures at cycles 0 and 7, consumer always ready.
    for (int i = 0; i < 10; i++) step(1'b1, !(i == 0 || i == 7), 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Stalled consumer, failures at cycles 2..6: last one dropped.
    do_reset(2);
    for (int i = 0; i < 7; i++) step(i >= 2, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1);

    // Full FIFO with simultaneous pop and push.
    do_reset(1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1);

    // Counter saturation.
    do_reset(1);
    repeat (300) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Reset pulse in the middle of a drain.
    do_reset(1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    do_reset(1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // chk_pass low without chk_valid is not an evaluation.
    do_reset(1);
    repeat (20) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // Randomised traffic in chunks so counters do not stay saturated.
    for (int c = 0; c < 6; c++) begin
      do_reset(1 + c % 2);
      for (int i = 0; i < 400; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1);
      end
      rst = 1'b0;
    end

    repeat (DEPTH + 2) step(1'b0, 1'b0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/assert_fail_logger.md
ASSERT_FAIL_LOGGER -- requirements
Module: assert_fail_logger

Interface
REQ-001 The block SHALL have parameter TS_W, default 16, meaning width of the cycle timestamp.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the saturating counters.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning failure-log FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 chk_valid  input  1  a check evaluation completes this cycle.
REQ-007 chk_pass  input  1  result of that evaluation (1=pass, 0=fail); don't-care when chk_valid=0.
REQ-008 log_valid  output  1  failure-log FIFO non-empty; head entry presented.
REQ-009 log_ready  input  1  consumer accepts head entry.
REQ-010 log_time  output  TS_W  timestamp of head failure entry.
REQ-011 fail_cnt  output  CNT_W  total failures since reset, saturating.
REQ-012 eval_cnt  output  CNT_W  total evaluations since reset, saturating.
REQ-013 first_fail_time  output  TS_W  timestamp of first failure since reset.
REQ-014 any_fail  output  1  sticky: at least one failure since reset.
REQ-015 overflow  output  1  sticky: at least one failure entry dropped.
REQ-016 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Internal cycle counter cyc SHALL be 0 in the first cycle after rst deasserts, +1 every cycle, wrap 2^TS_W-1 -> 0.
REQ-018 Failure event = chk_valid=1 and chk_pass=0 in a cycle; its timestamp SHALL be that cycle's cyc value.
REQ-019 Every cycle with chk_valid=1 SHALL increment eval_cnt by 1, holding at 2^CNT_W-1.
REQ-020 Every failure event SHALL increment fail_cnt by 1, holding at 2^CNT_W-1, regardless of FIFO state.
REQ-021 any_fail SHALL set on the cycle after the first failure event and hold until reset.
REQ-022 first_fail_time SHALL capture the timestamp of the first failure event only; later failures SHALL NOT change it.
REQ-023 A failure event SHALL push its timestamp into the FIFO; log_valid SHALL rise the following cycle (latency 1, no same-cycle bypass).
REQ-024 Pop SHALL occur when log_valid=1 and log_ready=1; next entry (if any) presented the following cycle.
REQ-025 log_time SHALL remain stable while log_valid=1 and log_ready=0.
REQ-026 FIFO SHALL preserve failure order; pointers wrap modulo DEPTH.
REQ-027 Push when full with no pop in same cycle: entry dropped, overflow set next cycle, FIFO contents unchanged.
REQ-028 Push when full with simultaneous pop: both occur, level stays DEPTH, no overflow.
REQ-029 Push and pop same cycle when non-full, non-empty: level unchanged.
REQ-030 log_ready while log_valid=0 SHALL have no effect.
REQ-031 fifo_level SHALL equal pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-032 While rst=1: log_valid=0, log_time=0, fail_cnt=0, eval_cnt=0, first_fail_time=0, any_fail=0, overflow=0, fifo_level=0, cyc=0.
REQ-033 rst asserted mid-operation SHALL flush FIFO and clear all counters/sticky flags on the next edge; chk_valid during rst ignored.

Verification
REQ-034 10 evaluations, cycles 0..9, fail at cycles 0 and 7, log_ready=1 -> entries 0 then 7, fail_cnt=2, eval_cnt=10, first_fail_time=0, overflow=0.
REQ-035 log_ready=0, DEPTH=4, failures at cycles 2,3,4,5,6 -> level 4, overflow=1 after cycle 6, fail_cnt=5, drained order 2,3,4,5.
REQ-036 FIFO full, log_ready=1 and failure same cycle -> level stays 4, overflow=0, newest entry at tail.
REQ-037 CNT_W=8, 300 consecutive failures with log_ready=1 -> fail_cnt=eval_cnt=255, held.
REQ-038 Three failures logged, rst pulsed 1 cycle mid-drain -> all outputs 0, next failure at cyc=1 gives log_time=1, first_fail_time=1.
REQ-039 chk_valid=0 with chk_pass=0 for 20 cycles -> no entries, eval_cnt=0, any_fail=0.
